// File: rtl/piezo_tune_seq_if.sv
// Signal bundle between the alarm-tune sequencer, the alarm clock FSM
// and the external piezo duration counter.
interface piezo_tune_seq_if;
    // start/stop are single-cycle request pulses with no ready/ack: a start
    // is taken only when busy is low, a stop is taken in any busy state.
    // note_over is a level from the duration counter, sampled every cycle.
    logic        start;
    logic        stop;
    logic        note_over;
    logic        dur_clr;
    logic        dur_en;
    logic [15:0] note_per;
    logic [7:0]  note_dur;
    logic        piezo_en;
    logic [2:0]  note_idx;
    logic        busy;
    logic        done;
    logic [2:0]  seq_state;

    modport master (
        input  start, stop, note_over,
        output dur_clr, dur_en, note_per, note_dur, piezo_en,
               note_idx, busy, done, seq_state
    );

    modport slave (
        output start, stop, note_over,
        input  dur_clr, dur_en, note_per, note_dur, piezo_en,
               note_idx, busy, done, seq_state
    );
endinterface

// File: rtl/piezo_tune_seq.sv
// Alarm-tune sequencer: walks an 8-note ROM, makes the 0.01 s tick and gaps.
// Optional tempo select (1x/2x/4x/8x) is enabled with PIEZO_TUNE_TEMPO_EN.
module piezo_tune_seq #(
    parameter int TICK_DIV  = 500000,
    parameter int GAP_TICKS = 5,
    parameter int REPEATS   = 3
) (
    input  logic clk,
    input  logic rst,
`ifdef PIEZO_TUNE_TEMPO_EN
    input  logic [1:0] tempo,
`endif
    piezo_tune_seq_if.master bus
);
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int GW = $clog2(GAP_TICKS + 1);

    typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, DONE} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] tick_cnt;
    logic [TW-1:0] tick_term;
    logic          tick;
    logic [GW-1:0] gap_cnt, gap_nxt;
    logic [7:0]    rep_cnt, rep_nxt;
    logic [2:0]    idx_q, idx_nxt;
    logic [15:0]   per_q;
    logic [7:0]    dur_q;
    logic          clr_q;
    logic          pz_q;
    logic          done_q;
    logic          abort;

`ifdef PIEZO_TUNE_TEMPO_EN
    logic [1:0] tempo_q;
    assign tick_term = TW'((TICK_DIV >> tempo_q) - 1);
`else
    assign tick_term = TW'(TICK_DIV - 1);
`endif

    assign tick = (tick_cnt == tick_term);

    // {period, duration}; index 7 is a rest
    function automatic logic [23:0] rom(input logic [2:0] i);
        case (i)
            3'd0:    rom = {16'd47778, 8'd20};
            3'd1:    rom = {16'd37922, 8'd20};
            3'd2:    rom = {16'd31888, 8'd20};
            3'd3:    rom = {16'd23889, 8'd40};
            3'd4:    rom = {16'd31888, 8'd20};
            3'd5:    rom = {16'd37922, 8'd20};
            3'd6:    rom = {16'd47778, 8'd40};
            default: rom = {16'd0,     8'd30};
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx_q;
        rep_nxt   = rep_cnt;
        gap_nxt   = gap_cnt;
        abort     = 1'b0;
        if (state != IDLE && bus.stop) begin
            state_nxt = IDLE;
            abort     = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state_nxt = LOAD;
                        idx_nxt   = 3'd0;
                        rep_nxt   = 8'd0;
                    end
                end
                LOAD: state_nxt = PLAY;
                PLAY: begin
                    if (bus.note_over) begin
                        state_nxt = GAP;
                        gap_nxt   = '0;
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (gap_cnt == GW'(GAP_TICKS - 1)) begin
                            if (idx_q != 3'd7) begin
                                idx_nxt   = idx_q + 3'd1;
                                state_nxt = LOAD;
                            end else if (REPEATS == 0 || int'(rep_cnt) < REPEATS - 1) begin
                                // rep_cnt only matters for finite REPEATS; saturate for endless mode
                                if (rep_cnt != 8'hFF) rep_nxt = rep_cnt + 8'd1;
                                idx_nxt   = 3'd0;
                                state_nxt = LOAD;
                            end else begin
                                state_nxt = DONE;
                            end
                        end else begin
                            gap_nxt = gap_cnt + GW'(1);
                        end
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            gap_cnt  <= '0;
            rep_cnt  <= '0;
            idx_q    <= '0;
            per_q    <= '0;
            dur_q    <= '0;
            clr_q    <= 1'b0;
            pz_q     <= 1'b0;
            done_q   <= 1'b0;
`ifdef PIEZO_TUNE_TEMPO_EN
            tempo_q  <= '0;
`endif
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_nxt;
            rep_cnt <= rep_nxt;
            idx_q   <= idx_nxt;
            // Held at 0 through LOAD so PLAY and GAP both start a fresh tick period
            if (state == LOAD || state_nxt == LOAD || (state == PLAY && state_nxt == GAP))
                tick_cnt <= '0;
            else if (tick)
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + TW'(1);
            if (state_nxt == LOAD)
                {per_q, dur_q} <= rom(idx_nxt);
            clr_q  <= (state_nxt == LOAD) || (state_nxt == GAP) || abort;
            pz_q   <= (state_nxt == PLAY) && (per_q != 16'd0);
            done_q <= (state_nxt == DONE);
`ifdef PIEZO_TUNE_TEMPO_EN
            if (state == IDLE && state_nxt == LOAD)
                tempo_q <= tempo;
`endif
        end
    end

    assign bus.dur_clr   = clr_q;
    assign bus.dur_en    = tick && (state == PLAY);
    assign bus.note_per  = per_q;
    assign bus.note_dur  = dur_q;
    assign bus.piezo_en  = pz_q;
    assign bus.note_idx  = idx_q;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.seq_state = state;
endmodule

// File: doc/piezo_tune_seq.md
Name: piezo_tune_seq

Overview:
- Alarm-tune sequencer. Walks an 8-entry note ROM and drives note period/duration to the piezo tone generator and the external piezo duration counter.
- Generates the 0.01 s enable tick, clears the duration counter between notes, and inserts inter-note gaps.
- Repeats the tune a configurable number of times.
- Started and stopped by the alarm clock FSM.

Parameters:
- TICK_DIV, 500000: clk cycles per 0.01 s tick (50 MHz clock).
- GAP_TICKS, 5: silent ticks between notes.
- REPEATS, 3: passes through the tune before done; 0 = loop until stop.

Ports:
- clk  input  1  system clock (50 MHz)
- rst  input  1  synchronous active-high reset
- start  input  1  pulse; begin tune (ignored while busy)
- stop  input  1  pulse; abort tune
- note_over  input  1  from duration counter; high when count == note_dur
- dur_clr  output  1  clear duration counter
- dur_en  output  1  0.01 s tick to duration counter
- note_per  output  16  tone period in clk cycles; 0 = rest
- note_dur  output  8  note length in ticks
- piezo_en  output  1  tone generator enable
- note_idx  output  3  current ROM index
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse at normal completion

Behaviour:
- Reset: synchronous, active-high. Clock is clk, reset is rst. While rst is high:
  - state = IDLE.
  - All outputs 0: note_per, note_dur, note_idx, dur_clr, dur_en, piezo_en, busy, done.
  - tick_cnt = 0, gap_cnt = 0, rep_cnt = 0.
  - Reset mid-tune aborts immediately and does not pulse done.
- ROM, index 0..7 (per / dur):
  - 47778/20, 37922/20, 31888/20, 23889/40, 31888/20, 37922/20, 47778/40, 0/30.
  - Index 7 is a rest.
- Tick generation:
  - tick_cnt counts 0..TICK_DIV-1 and wraps.
  - tick = (tick_cnt == TICK_DIV-1).
  - tick_cnt is cleared to 0 on entry to LOAD and to GAP.
- dur_en = tick AND (state == PLAY). dur_en is 0 in all other states.
- States:
  - IDLE: on start & !stop -> LOAD, with note_idx = 0 and rep_cnt = 0.
  - LOAD: lasts 1 cycle.
    - note_per and note_dur are registered from ROM[note_idx].
    - dur_clr = 1.
    - -> PLAY.
  - PLAY:
    - piezo_en = (note_per != 0).
    - While note_over = 0, stay in PLAY.
    - In the cycle note_over = 1, go -> GAP with gap_cnt = 0.
    - PLAY therefore lasts note_dur*TICK_DIV + 1 cycles.
    - note_dur = 0 gives a PLAY of 1 cycle.
  - GAP:
    - piezo_en = 0, dur_clr = 1.
    - Each tick increments gap_cnt.
    - On the tick where gap_cnt == GAP_TICKS-1, gap ends (GAP_TICKS*TICK_DIV cycles).
    - If gap ends with note_idx < 7: note_idx+1, -> LOAD.
    - If gap ends with note_idx == 7 and (REPEATS == 0 or rep_cnt < REPEATS-1): rep_cnt+1, note_idx = 0, -> LOAD.
    - Otherwise -> DONE.
  - DONE: done = 1 for 1 cycle, -> IDLE.
- stop in any non-IDLE state:
  - -> IDLE the next cycle.
  - In that cycle: piezo_en = 0, dur_clr = 1, done = 0.
  - note_idx holds its last value.
- Simultaneous events:
  - start and stop in the same cycle: stop wins; remain IDLE.
  - start while busy: ignored.
- rep_cnt is 8 bits and saturates at 255 when REPEATS == 0.
- All outputs are registered except dur_en and busy, which are decoded from registered state.

Optional Feature:
- Macro: PIEZO_TUNE_TEMPO_EN.
- Defined:
  - Adds input tempo[1:0].
  - tempo is sampled into a register when leaving IDLE.
  - The tick terminal count becomes (TICK_DIV >> tempo) - 1: 1x, 2x, 4x and 8x speed.
  - Gaps scale the same way.
- Undefined:
  - The tempo port does not exist.
  - The terminal count is TICK_DIV-1.

Test Plan:
- All tests use TICK_DIV = 10 and GAP_TICKS = 5, with a behavioural 8-bit duration counter model attached.
- Reset: assert rst for 3 cycles during PLAY of note 3 -> the next cycle has all outputs 0, busy = 0, no done pulse; a subsequent start plays from note_idx = 0.
- Single pass, REPEATS = 1: start pulse ->
  - note_idx steps 0..7.
  - note_per = 47778 in note 0 PLAY.
  - piezo_en = 0 throughout note 7.
  - busy is high for 2517 cycles, then a single done pulse.
- Stop mid-note: stop at cycle 50 of note 2 PLAY -> next cycle IDLE, piezo_en = 0, dur_clr = 1, done never asserts, note_idx = 2.
- Collisions:
  - start and stop together in IDLE -> stays IDLE.
  - start pulses during PLAY -> no restart; note_idx is unchanged.
- REPEATS = 0: run 3 full passes -> note_idx wraps 7 -> 0 each pass, done never asserts; stop then ends in IDLE.
- PIEZO_TUNE_TEMPO_EN with tempo = 2'b01 -> note 0 PLAY lasts 20*5+1 = 101 cycles and each gap lasts 25 cycles.
